// File: rtl/gold_sched_pkg.sv
// Shared types and default sizing for the Gold-code generator scheduler.
// Latency: n/a (types only). Backpressure: n/a.
// Consumers import gold_sched_pkg::* for state_e and the default widths.
package gold_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_N      = 63;
    localparam int CNT_W      = $clog2(DEF_N);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr_i, wrapping.
// Latency: combinational. Backpressure: none, the caller registers the result.
module rr_arbiter
    import gold_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [CH_W-1:0]   id_o,
    output logic              vld_o
);

    logic [CH_W-1:0] k;
    logic            found;

    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        k     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            k = CH_W'((int'(ptr_i) + i) % NUM_CH);
            if (!found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                id_o     = k;
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/gold_code_scheduler.sv
// Shares one Gold generator among NUM_CH channels; optional watchdog via GOLD_SCHED_TIMEOUT_EN.
// Latency: req->gnt 1 cycle, strobe->chip 1 cycle, last strobe->done 1 cycle.
// Backpressure: load held on gen_tvalid_o until gen_tready_i; run waits on chip strobes.
module gold_code_scheduler
    import gold_sched_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int N           = DEF_N,
    parameter int LENGTH      = $clog2(N),
    parameter int CH_W        = $clog2(NUM_CH),
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                     clkin,
    input  logic                     rstn,
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [NUM_CH*LENGTH-1:0] idx_i,
    output logic [NUM_CH-1:0]        gnt_o,
    output logic [NUM_CH-1:0]        done_o,
    output logic [LENGTH-1:0]        gen_tdata_o,
    output logic                     gen_tvalid_o,
    input  logic                     gen_tready_i,
    output logic                     gen_run_o,
    input  logic                     chip_strobe_i,
    input  logic                     chip_i,
    output logic                     chip_o,
    output logic                     chip_valid_o,
    output logic [CH_W-1:0]          chip_ch_o,
    output logic                     busy_o,
    output logic                     err_o
);

    // Never narrower than the default code length's counter.
    localparam int CW = ($clog2(N) > CNT_W) ? $clog2(N) : CNT_W;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   gnt_q, gnt_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic [CH_W-1:0]     id_q, id_d;
    logic [LENGTH-1:0]   tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                run_q, run_d;
    logic                chip_q, chip_d;
    logic                chip_vld_q, chip_vld_d;
    logic [CH_W-1:0]     chip_ch_q, chip_ch_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic                busy_q, busy_d;

    logic [NUM_CH-1:0]   arb_gnt;
    logic [CH_W-1:0]     arb_id;
    logic                arb_vld;
    logic [CH_W-1:0]     next_ptr;

`ifdef GOLD_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                err_q, err_d;
`endif

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_arbiter (
        .req_i  (req_i),
        .ptr_i  (rr_q),
        .gnt_o  (arb_gnt),
        .id_o   (arb_id),
        .vld_o  (arb_vld)
    );

    assign next_ptr = (id_q == CH_W'(NUM_CH - 1)) ? '0 : id_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        id_d       = id_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        run_d      = run_q;
        chip_d     = chip_q;
        chip_vld_d = 1'b0;
        chip_ch_d  = chip_ch_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
`ifdef GOLD_SCHED_TIMEOUT_EN
        wd_d       = '0;
        err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d  = LOAD;
                    gnt_d    = arb_gnt;
                    id_d     = arb_id;
                    tdata_d  = idx_i[int'(arb_id)*LENGTH +: LENGTH];
                    tvalid_d = 1'b1;
                end
            end
            LOAD: begin
                if (tvalid_q && gen_tready_i) begin
                    state_d  = RUN;
                    tvalid_d = 1'b0;
                    run_d    = 1'b1;
                end
            end
            RUN: begin
                if (chip_strobe_i) begin
                    chip_d     = chip_i;
                    chip_vld_d = 1'b1;
                    chip_ch_d  = id_q;
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                        done_d  = gnt_q;
                        run_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                rr_d    = next_ptr;
            end
            default: state_d = IDLE;
        endcase
`ifdef GOLD_SCHED_TIMEOUT_EN
        // Idle cycles in LOAD/RUN accumulate; any transfer or strobe restarts the count.
        if ((state_q == LOAD && !(tvalid_q && gen_tready_i)) ||
            (state_q == RUN && !chip_strobe_i)) begin
            if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                err_d    = 1'b1;
                state_d  = IDLE;
                gnt_d    = '0;
                tvalid_d = 1'b0;
                run_d    = 1'b0;
                cnt_d    = '0;
                rr_d     = next_ptr;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clkin) begin
        if (!rstn) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            id_q       <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            run_q      <= 1'b0;
            chip_q     <= 1'b0;
            chip_vld_q <= 1'b0;
            chip_ch_q  <= '0;
            cnt_q      <= '0;
            rr_q       <= '0;
            busy_q     <= 1'b0;
`ifdef GOLD_SCHED_TIMEOUT_EN
            wd_q       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            id_q       <= id_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            run_q      <= run_d;
            chip_q     <= chip_d;
            chip_vld_q <= chip_vld_d;
            chip_ch_q  <= chip_ch_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            busy_q     <= busy_d;
`ifdef GOLD_SCHED_TIMEOUT_EN
            wd_q       <= wd_d;
            err_q      <= err_d;
`endif
        end
    end

    assign gnt_o        = gnt_q;
    assign done_o       = done_q;
    assign gen_tdata_o  = tdata_q;
    assign gen_tvalid_o = tvalid_q;
    assign gen_run_o    = run_q;
    assign chip_o       = chip_q;
    assign chip_valid_o = chip_vld_q;
    assign chip_ch_o    = chip_ch_q;
    assign busy_o       = busy_q;

`ifdef GOLD_SCHED_TIMEOUT_EN
    assign err_o = err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYC;
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gold_code_scheduler.sv
// Directed bench for gold_code_scheduler: reset, single grant, backpressure, mid-run reset, fairness.
module tb_gold_code_scheduler;

    localparam int NUM_CH = 4;
    localparam int N      = 63;
    localparam int LENGTH = 6;
    localparam int CH_W   = 2;

    logic                     clkin;
    logic                     rstn;
    logic [NUM_CH-1:0]        req_i;
    logic [NUM_CH*LENGTH-1:0] idx_i;
    logic [NUM_CH-1:0]        gnt_o;
    logic [NUM_CH-1:0]        done_o;
    logic [LENGTH-1:0]        gen_tdata_o;
    logic                     gen_tvalid_o;
    logic                     gen_tready_i;
    logic                     gen_run_o;
    logic                     chip_strobe_i;
    logic                     chip_i;
    logic                     chip_o;
    logic                     chip_valid_o;
    logic [CH_W-1:0]          chip_ch_o;
    logic                     busy_o;
    logic                     err_o;

    int n_pass  = 0;
    int n_total = 0;
    logic [6:0] lfsr = 7'h5A;
    logic [5:0] idx_tab [NUM_CH];

    gold_code_scheduler #(
        .NUM_CH (NUM_CH),
        .N      (N)
    ) dut (
        .clkin         (clkin),
        .rstn          (rstn),
        .req_i         (req_i),
        .idx_i         (idx_i),
        .gnt_o         (gnt_o),
        .done_o        (done_o),
        .gen_tdata_o   (gen_tdata_o),
        .gen_tvalid_o  (gen_tvalid_o),
        .gen_tready_i  (gen_tready_i),
        .gen_run_o     (gen_run_o),
        .chip_strobe_i (chip_strobe_i),
        .chip_i        (chip_i),
        .chip_o        (chip_o),
        .chip_valid_o  (chip_valid_o),
        .chip_ch_o     (chip_ch_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_idx();
        for (int k = 0; k < NUM_CH; k++) idx_i[k*LENGTH +: LENGTH] = idx_tab[k];
    endtask

    // Drive n back-to-back strobes; count chips forwarded with the right data and channel.
    task automatic run_chips(input int n, input int ch, output int good, output bit early_done);
        logic b;
        good = 0;
        early_done = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = lfsr[0];
            lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            chip_strobe_i = 1'b1;
            chip_i = b;
            tick();
            if (chip_valid_o === 1'b1 && chip_o === b && chip_ch_o === CH_W'(ch)) good++;
            if (i < n - 1 && done_o !== '0) early_done = 1'b1;
        end
        chip_strobe_i = 1'b0;
    endtask

    initial begin
        int  good;
        bit  early;
        bit  stable;
        int  order [5];
        idx_tab[0] = 6'd11;
        idx_tab[1] = 6'd22;
        idx_tab[2] = 6'd5;
        idx_tab[3] = 6'd33;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

        rstn = 1'b0;
        req_i = 4'hF;
        idx_i = '0;
        set_idx();
        gen_tready_i = 1'b1;
        chip_strobe_i = 1'b0;
        chip_i = 1'b0;

        // Reset with every channel requesting
        tick();
        tick();
        check("rst_gnt", gnt_o, 0);
        check("rst_done", done_o, 0);
        check("rst_tvalid", gen_tvalid_o, 0);
        check("rst_tdata", gen_tdata_o, 0);
        check("rst_run", gen_run_o, 0);
        check("rst_chip", {chip_o, chip_valid_o, chip_ch_o}, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);

        rstn = 1'b1;
        req_i = 4'b0000;
        tick();
        check("idle_busy", busy_o, 0);

        // Single request on channel 2
        req_i = 4'b0100;
        tick();
        check("single_gnt", gnt_o, 4'b0100);
        check("single_tvalid", gen_tvalid_o, 1);
        check("single_tdata", gen_tdata_o, 5);
        check("single_run_pre", gen_run_o, 0);
        check("single_busy", busy_o, 1);
        tick();
        req_i = 4'b0000;
        check("single_run", gen_run_o, 1);
        check("single_tvalid_drop", gen_tvalid_o, 0);
        run_chips(N, 2, good, early);
        check("single_chips", good, N);
        check("single_early_done", early, 0);
        check("single_done", done_o, 4'b0100);
        check("single_run_done", gen_run_o, 0);
        check("single_gnt_done", gnt_o, 4'b0100);
        tick();
        check("single_done_pulse", done_o, 0);
        check("single_gnt_clr", gnt_o, 0);
        check("single_idle", busy_o, 0);

        // Backpressure on channel 3, with idx changes and stray strobes in LOAD
        req_i = 4'b1000;
        gen_tready_i = 1'b0;
        tick();
        check("bp_gnt", gnt_o, 4'b1000);
        check("bp_tdata", gen_tdata_o, 33);
        stable = 1'b1;
        idx_i = '1;
        for (int i = 0; i < 10; i++) begin
            chip_strobe_i = i[0];
            tick();
            if (gen_tvalid_o !== 1'b1 || gen_tdata_o !== 6'd33 || gen_run_o !== 1'b0 ||
                chip_valid_o !== 1'b0) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        chip_strobe_i = 1'b0;
        gen_tready_i = 1'b1;
        set_idx();
        tick();
        check("bp_run", gen_run_o, 1);
        check("bp_tvalid_drop", gen_tvalid_o, 0);

        // Reset after chip 30
        run_chips(30, 3, good, early);
        check("mid_chips", good, 30);
        rstn = 1'b0;
        tick();
        check("mid_rst_gnt", gnt_o, 0);
        check("mid_rst_done", done_o, 0);
        check("mid_rst_run", gen_run_o, 0);
        check("mid_rst_cv", chip_valid_o, 0);
        check("mid_rst_busy", busy_o, 0);

        // Fairness with all channels requesting: 0,1,2,3,0
        rstn = 1'b1;
        req_i = 4'hF;
        for (int g = 0; g < 5; g++) begin
            tick();
            check($sformatf("rr%0d_gnt", g), gnt_o, 32'(1 << order[g]));
            check($sformatf("rr%0d_tdata", g), gen_tdata_o, idx_tab[order[g]]);
            tick();
            check($sformatf("rr%0d_run", g), gen_run_o, 1);
            run_chips(N, order[g], good, early);
            check($sformatf("rr%0d_chips", g), good, N);
            check($sformatf("rr%0d_early", g), early, 0);
            check($sformatf("rr%0d_done", g), done_o, 32'(1 << order[g]));
            tick();
            check($sformatf("rr%0d_idle", g), busy_o, 0);
        end

        // Lone requester is re-granted even though the pointer moved past it
        req_i = 4'b0001;
        tick();
        check("regrant_gnt", gnt_o, 4'b0001);

`ifdef GOLD_SCHED_TIMEOUT_EN
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        req_i = 4'b0010;
        tick();
        check("wd_gnt", gnt_o, 4'b0010);
        tick();
        req_i = 4'b0000;
        good = 0;
        early = 1'b0;
        for (int i = 0; i < 300 && good == 0; i++) begin
            tick();
            if (done_o !== '0) early = 1'b1;
            if (err_o === 1'b1) good = 1;
        end
        check("wd_err", good, 1);
        check("wd_no_done", early, 0);
        check("wd_gnt_clr", gnt_o, 0);
        check("wd_run_clr", gen_run_o, 0);
        req_i = 4'hF;
        tick();
        tick();
        check("wd_next_gnt", gnt_o, 4'b0100);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
